// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - size encodings, store FSM states and byte-enable mask helper
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        RDWAIT = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    // Expand a 4-bit byte enable into a 32-bit bit mask.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// rtl/store_lane_gen.sv - lane placement, byte enables and alignment check for SB/SH/SW
module store_lane_gen
    import mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [31:0] lanes,
    output logic [3:0]  be,
    output logic        misaligned
);

    logic [1:0] byte_lane;
    logic       half_hi;

    always_comb begin
        byte_lane  = BIG_ENDIAN ? (2'd3 - addr) : addr;
        half_hi    = BIG_ENDIAN ? ~addr[1] : addr[1];
        lanes      = data;
        be         = 4'b1111;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                lanes = {4{data[7:0]}};
                be    = 4'b0001 << byte_lane;
            end
            SIZE_HALF: begin
                lanes      = {2{data[15:0]}};
                be         = 4'b0011 << {half_hi, 1'b0};
                misaligned = addr[0];
            end
            SIZE_WORD: begin
                misaligned = (addr != 2'b00);
            end
            default: begin
                be         = 4'b0000;
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - MEM-stage store path with memory handshake; STORE_RMW_EN selects read-modify-write for memories without byte enables
module store_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              done,
    output logic              misalign
);

    state_t            state;
    state_t            state_next;
    state_t            first_access;
    logic              accept;
    logic [31:0]       lanes;
    logic [3:0]        be;
    logic              misaligned;
    logic              rsp_mis;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;

    store_lane_gen #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_lane_gen (
        .addr      (req_addr[1:0]),
        .size      (req_size),
        .data      (req_data),
        .lanes     (lanes),
        .be        (be),
        .misaligned(misaligned)
    );

    assign accept = req_valid && req_ready;

`ifdef STORE_RMW_EN
    // Full-word stores need no merge, so they bypass the read phase.
    assign first_access = (req_size == SIZE_WORD) ? WRITE : READ;
`else
    assign first_access = WRITE;
    logic unused_rmw;
    assign unused_rmw = ^{mem_rdata, mem_rvalid};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, RESP: begin
                if (accept) begin
                    state_next = misaligned ? RESP : first_access;
                end else begin
                    state_next = IDLE;
                end
            end
`ifdef STORE_RMW_EN
            READ: begin
                if (mem_ready) state_next = RDWAIT;
            end
            RDWAIT: begin
                if (mem_rvalid) state_next = WRITE;
            end
`endif
            WRITE: begin
                if (mem_ready) state_next = RESP;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields are captured at accept so the core may move on immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rsp_mis <= 1'b0;
        end else if (accept) begin
            rsp_mis <= misaligned;
            if (!misaligned) begin
                addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                wdata_q <= lanes;
                be_q    <= be;
            end
        end
`ifdef STORE_RMW_EN
        else if (state == RDWAIT && mem_rvalid) begin
            wdata_q <= (mem_rdata & ~be_to_mask(be_q)) | (wdata_q & be_to_mask(be_q));
        end
`endif
    end

    always_comb begin
        req_ready = !reset && (state == IDLE || state == RESP);
        mem_valid = (state == WRITE) || (state == READ);
        mem_we    = (state == WRITE);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
`ifdef STORE_RMW_EN
        mem_be    = (state == WRITE) ? 4'b1111 : be_q;
`else
        mem_be    = be_q;
`endif
        done      = (state == RESP) && !rsp_mis;
        misalign  = (state == RESP) && rsp_mis;
    end

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - directed table-driven bench for store_unit
module tb_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_data;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        done;
    logic        misalign;

    int errors = 0;
    int checks = 0;

    store_unit dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_data  (req_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid),
        .done      (done),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
        logic        mis;
        logic [31:0] eaddr;
        logic [3:0]  ebe;
        logic [31:0] ewdata;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic scramble_req();
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_size  = 2'b11;
        req_data  = 32'h5A5A_5A5A;
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        req_valid = 1'b1;
        req_addr  = a;
        req_size  = s;
        req_data  = d;
    endtask

    initial begin
        reset      = 1'b1;
        mem_ready  = 1'b1;
        mem_rdata  = 32'h0;
        mem_rvalid = 1'b0;
        scramble_req();

        vecs[0] = '{32'h0000_1003, 2'b00, 32'h0000_00A5, 1'b0, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5};
        vecs[1] = '{32'h0000_2002, 2'b01, 32'h1234_BEEF, 1'b0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF};
        vecs[2] = '{32'h0000_2000, 2'b10, 32'h1234_BEEF, 1'b0, 32'h0000_2000, 4'b1111, 32'h1234_BEEF};
        vecs[3] = '{32'h0000_0040, 2'b00, 32'h1234_5678, 1'b0, 32'h0000_0040, 4'b0001, 32'h7878_7878};
        vecs[4] = '{32'h0000_1000, 2'b01, 32'hAAAA_5555, 1'b0, 32'h0000_1000, 4'b0011, 32'h5555_5555};
        vecs[5] = '{32'h0000_2001, 2'b01, 32'h1234_BEEF, 1'b1, 32'h0,         4'b0000, 32'h0};
        vecs[6] = '{32'h0000_2002, 2'b10, 32'h1234_BEEF, 1'b1, 32'h0,         4'b0000, 32'h0};
        vecs[7] = '{32'h0000_0000, 2'b11, 32'h1234_BEEF, 1'b1, 32'h0,         4'b0000, 32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_we",    mem_we,    0);
        check("rst_done",      done,      0);
        check("rst_misalign",  misalign,  0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_be",    mem_be,    0);
        check("rst_req_ready", req_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);

        // Single stores, memory always ready
        for (int i = 0; i < 8; i++) begin
`ifdef STORE_RMW_EN
            if (!vecs[i].mis && vecs[i].size != 2'b10) continue;
`endif
            @(negedge clk);
            drive_req(vecs[i].addr, vecs[i].size, vecs[i].data);
            check($sformatf("v%0d_req_ready", i), req_ready, 1);
            @(posedge clk);
            #1 scramble_req();
            @(negedge clk);
            if (vecs[i].mis) begin
                check($sformatf("v%0d_misalign", i),  misalign,  1);
                check($sformatf("v%0d_mem_valid", i), mem_valid, 0);
                check($sformatf("v%0d_done", i),      done,      0);
                @(negedge clk);
                check($sformatf("v%0d_misalign_end", i), misalign, 0);
            end else begin
                check($sformatf("v%0d_mem_valid", i), mem_valid, 1);
                check($sformatf("v%0d_mem_we", i),    mem_we,    1);
                check($sformatf("v%0d_mem_addr", i),  mem_addr,  vecs[i].eaddr);
                check($sformatf("v%0d_mem_be", i),    mem_be,    vecs[i].ebe);
                check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].ewdata);
                check($sformatf("v%0d_req_ready_busy", i), req_ready, 0);
                check($sformatf("v%0d_done_early", i), done, 0);
                @(negedge clk);
                check($sformatf("v%0d_done", i),       done,      1);
                check($sformatf("v%0d_valid_drop", i), mem_valid, 0);
                check($sformatf("v%0d_no_mis", i),     misalign,  0);
                @(negedge clk);
                check($sformatf("v%0d_done_end", i), done, 0);
            end
        end

`ifndef STORE_RMW_EN
        // Memory stalls for 5 cycles
        begin
            int dones;
            mem_ready = 1'b0;
            @(negedge clk);
            drive_req(32'h0000_3000, 2'b10, 32'hDEAD_BEEF);
            @(posedge clk);
            #1 scramble_req();
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                check($sformatf("stall%0d_valid", c), mem_valid, 1);
                check($sformatf("stall%0d_addr", c),  mem_addr,  32'h0000_3000);
                check($sformatf("stall%0d_wdata", c), mem_wdata, 32'hDEAD_BEEF);
                check($sformatf("stall%0d_be", c),    mem_be,    4'b1111);
                check($sformatf("stall%0d_we", c),    mem_we,    1);
                check($sformatf("stall%0d_ready", c), req_ready, 0);
                check($sformatf("stall%0d_done", c),  done,      0);
            end
            mem_ready = 1'b1;
            dones = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (c == 0) check("stall_done_after_hs", done, 1);
                if (done) dones++;
            end
            check("stall_single_done", dones, 1);
        end

        // Back-to-back: second request accepted in the RESP cycle
        @(negedge clk);
        drive_req(32'h0000_1003, 2'b00, 32'h0000_00A5);
        @(negedge clk);
        check("b2b_first_valid", mem_valid, 1);
        check("b2b_first_be",    mem_be,    4'b1000);
        drive_req(32'h0000_2002, 2'b01, 32'h1234_BEEF);
        @(negedge clk);
        check("b2b_first_done",  done,      1);
        check("b2b_resp_ready",  req_ready, 1);
        @(negedge clk);
        check("b2b_second_valid", mem_valid, 1);
        check("b2b_second_addr",  mem_addr,  32'h0000_2000);
        check("b2b_second_be",    mem_be,    4'b1100);
        check("b2b_second_wdata", mem_wdata, 32'hBEEF_BEEF);
        scramble_req();
        @(negedge clk);
        check("b2b_second_done", done, 1);
        @(negedge clk);

        // Reset while in WRITE abandons the store
        mem_ready = 1'b0;
        drive_req(32'h0000_4000, 2'b10, 32'h0BAD_F00D);
        @(negedge clk);
        scramble_req();
        check("rstw_valid_before", mem_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rstw_valid_dropped", mem_valid, 0);
        check("rstw_no_done",       done,      0);
        check("rstw_no_misalign",   misalign,  0);
        check("rstw_ready_in_rst",  req_ready, 0);
        reset     = 1'b0;
        mem_ready = 1'b1;
        begin
            int spurious;
            spurious = 0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (done || misalign || mem_valid) spurious++;
            end
            check("rstw_quiet_after", spurious, 0);
        end
        check("rstw_ready_after", req_ready, 1);
`else
        // Read-modify-write byte store
        @(negedge clk);
        drive_req(32'h0000_3001, 2'b00, 32'h0000_0077);
        @(posedge clk);
        #1 scramble_req();
        @(negedge clk);
        check("rmw_read_valid", mem_valid, 1);
        check("rmw_read_we",    mem_we,    0);
        check("rmw_read_addr",  mem_addr,  32'h0000_3000);
        @(negedge clk);
        check("rmw_wait_valid", mem_valid, 0);
        mem_rdata  = 32'h1122_3344;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        check("rmw_write_valid", mem_valid, 1);
        check("rmw_write_we",    mem_we,    1);
        check("rmw_write_wdata", mem_wdata, 32'h1122_7744);
        check("rmw_write_be",    mem_be,    4'b1111);
        @(negedge clk);
        check("rmw_done", done, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
